// File: rtl/mmio_io_hub_if.sv
// MMIO request/response bus between the CPU execute stage and the I/O hub.
// The master drives a request in one cycle; the slave returns registered load
// data on rsp_rdata at the following edge.
interface mmio_io_hub_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [31:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output rsp_rdata
  );
endinterface

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: UART RX/TX FIFOs, cycle/instruction counters and
// NUM_EVT generic event counters behind a word-addressed register window.
// Optional build macro MMIO_OCC_STATUS_EN adds RX/TX occupancy fields to
// STATUS[15:8] and STATUS[23:16].
module mmio_io_hub #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_EVT    = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  mmio_io_hub_if.slave                           bus,
  input  logic                                   inst_retire,
  input  logic [((NUM_EVT > 0) ? NUM_EVT : 1)-1:0] evt,
  input  logic [7:0]                             uart_rx_data,
  input  logic                                   uart_rx_valid,
  output logic                                   uart_rx_ready,
  output logic [7:0]                             uart_tx_data,
  output logic                                   uart_tx_valid,
  input  logic                                   uart_tx_ready
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int EVT_N = (NUM_EVT > 0) ? NUM_EVT : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_RXDATA = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] A_TXDATA = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] A_CYCLE  = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] A_INSTR  = ADDR_WIDTH'(32'h14);
  localparam logic [ADDR_WIDTH-1:0] A_CTRRST = ADDR_WIDTH'(32'h18);
  localparam logic [ADDR_WIDTH-1:0] A_EVT0   = ADDR_WIDTH'(32'h1C);

  logic [ADDR_WIDTH-1:0] addr_w;
  logic                  rd_req, wr_req;
  logic                  unused_bits;

  // byte-lane bits of the address and upper store bits carry no meaning here
  assign addr_w      = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rd_req      = bus.req_valid && !bus.req_we;
  assign wr_req      = bus.req_valid && bus.req_we;
  assign unused_bits = ^{bus.req_addr[1:0], bus.req_wdata[31:8]};

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full       = (rx_cnt == DEPTH_C);
  assign rx_empty      = (rx_cnt == '0);
  // held low while in reset so the receiver never hands over a byte then
  assign uart_rx_ready = rst_n && !rx_full;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = rd_req && (addr_w == A_RXDATA) && !rx_empty;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_wr, tx_deq, tx_push, tx_drop, tx_ovf;

  assign tx_full       = (tx_cnt == DEPTH_C);
  assign uart_tx_valid = (tx_cnt != '0);
  assign uart_tx_data  = tx_mem[tx_rp];
  assign tx_deq        = uart_tx_valid && uart_tx_ready;
  assign tx_wr         = wr_req && (addr_w == A_TXDATA);
  // a slot freed by the transmitter on the same edge makes room for the push
  assign tx_push       = tx_wr && (!tx_full || tx_deq);
  assign tx_drop       = tx_wr && tx_full && !tx_deq;

  // FIFO payload storage, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wp] <= bus.req_wdata[7:0];
  end

  // FIFO pointers, counts and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_deq)  tx_rp <= tx_rp + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_deq);
      if (tx_drop)
        tx_ovf <= 1'b1;
      else if (wr_req && (addr_w == A_STATUS))
        tx_ovf <= 1'b0;
    end
  end

  // counters
  logic [CNT_WIDTH-1:0] cnt_cycle, cnt_instr;
  logic [CNT_WIDTH-1:0] cnt_evt [EVT_N];
  logic                 ctr_clr;

  assign ctr_clr = wr_req && (addr_w == A_CTRRST);

  // free-running counters; a counter-reset write wins over that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cycle <= '0;
      cnt_instr <= '0;
      for (int i = 0; i < EVT_N; i++) cnt_evt[i] <= '0;
    end else if (ctr_clr) begin
      cnt_cycle <= '0;
      cnt_instr <= '0;
      for (int i = 0; i < EVT_N; i++) cnt_evt[i] <= '0;
    end else begin
      cnt_cycle <= cnt_cycle + CNT_WIDTH'(1);
      cnt_instr <= cnt_instr + CNT_WIDTH'(inst_retire);
      for (int i = 0; i < NUM_EVT; i++) cnt_evt[i] <= cnt_evt[i] + CNT_WIDTH'(evt[i]);
    end
  end

`ifdef MMIO_OCC_STATUS_EN
  function automatic logic [7:0] occ8(input logic [CW-1:0] c);
    if (32'(c) > 32'd255) return 8'hFF;
    return 8'(c);
  endfunction
`endif

  logic [31:0] status_val, rd_val, rsp_q;

  // STATUS word assembled from FIFO flags
  always_comb begin
    status_val    = '0;
    status_val[0] = !tx_full;
    status_val[1] = !rx_empty;
    status_val[2] = tx_ovf;
`ifdef MMIO_OCC_STATUS_EN
    status_val[15:8]  = occ8(rx_cnt);
    status_val[23:16] = occ8(tx_cnt);
`endif
  end

  // read mux, sampled from pre-edge state in the request cycle
  always_comb begin
    case (addr_w)
      A_STATUS: rd_val = status_val;
      A_RXDATA: rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
      A_CYCLE:  rd_val = 32'(cnt_cycle);
      A_INSTR:  rd_val = 32'(cnt_instr);
      default:  rd_val = 32'h0;
    endcase
    for (int i = 0; i < NUM_EVT; i++)
      if (addr_w == A_EVT0 + ADDR_WIDTH'(4 * i)) rd_val = 32'(cnt_evt[i]);
  end

  // load data register; holds across writes and idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_q <= '0;
    else if (rd_req)
      rsp_q <= rd_val;
  end

  assign bus.rsp_rdata = rsp_q;

endmodule
